// File: rtl/rat_io_responder_if.sv
// MCU port bus between the RAT processor and its peripheral targets.
// Valid/ready contract: IO_STRB is a one-cycle write valid that is always accepted (no ready);
// IN_PORT is valid combinationally in the same cycle as PORT_ID.
interface rat_io_responder_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB, input IN_PORT);
  modport slave  (input PORT_ID, input OUT_PORT, input IO_STRB, output IN_PORT);
endinterface

// File: rtl/rat_io_responder.sv
// RAT port-bus target: LED/7-seg write registers, read mux, and a debounced
// push-button that raises a level interrupt until software acknowledges it.
module rat_io_responder #(
  parameter logic [7:0] SW_ID     = 8'h20,
  parameter logic [7:0] STAT_ID   = 8'h21,
  parameter logic [7:0] LED_ID    = 8'h40,
  parameter logic [7:0] SSEG_ID   = 8'h81,
  parameter logic [7:0] ACK_ID    = 8'hF0,
  parameter int         DB_CYCLES = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  rat_io_responder_if.slave        bus,
  input  logic [7:0]               SWITCHES,
  input  logic                     BTN,
  output logic [7:0]               LEDS,
  output logic [7:0]               SSEG_VAL,
  output logic                     INT,
  output logic [1:0]               dbg_state_o
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_q, s2_q;
  logic          int_pend_q, int_pend_d;
  logic [7:0]    leds_q, leds_d;
  logic [7:0]    sseg_q, sseg_d;
  logic          press;
  logic          btn_db;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= LOW;
      cnt_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      int_pend_q <= 1'b0;
      leds_q     <= 8'h00;
      sseg_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_q       <= BTN;
      s2_q       <= s1_q;
      int_pend_q <= int_pend_d;
      leds_q     <= leds_d;
      sseg_q     <= sseg_d;
    end
  end

  // The counter restarts on every bounce back toward the stable level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_db = (state_q == HIGH) || (state_q == WAIT_LOW);

  // A press completing in the same cycle as an ACK write keeps the interrupt set.
  always_comb begin
    leds_d     = leds_q;
    sseg_d     = sseg_q;
    int_pend_d = int_pend_q;
    if (bus.IO_STRB) begin
      if (bus.PORT_ID == LED_ID)  leds_d     = bus.OUT_PORT;
      if (bus.PORT_ID == SSEG_ID) sseg_d     = bus.OUT_PORT;
      if (bus.PORT_ID == ACK_ID)  int_pend_d = 1'b0;
    end
    if (press) int_pend_d = 1'b1;
  end

  always_comb begin
    bus.IN_PORT = 8'h00;
    if (bus.PORT_ID == SW_ID)        bus.IN_PORT = SWITCHES;
    else if (bus.PORT_ID == STAT_ID) bus.IN_PORT = {6'b0, btn_db, int_pend_q};
    else if (bus.PORT_ID == LED_ID)  bus.IN_PORT = leds_q;
    else if (bus.PORT_ID == SSEG_ID) bus.IN_PORT = sseg_q;
  end

  assign LEDS        = leds_q;
  assign SSEG_VAL    = sseg_q;
  assign INT         = int_pend_q;
  assign dbg_state_o = state_q;

endmodule
